// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the UART echo design: FSM state encodings,
// the receive bit-counter width and the bit positions of the status byte.
package tt_uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Indexes the 8 data bits of a frame.
  localparam int BIT_CNT_W = 3;

  // Status byte layout on uo_out.
  localparam int UO_EMPTY   = 0;
  localparam int UO_FULL    = 1;
  localparam int UO_FERR    = 2;
  localparam int UO_OVF     = 3;
  localparam int UO_TXD     = 4;
  localparam int UO_TX_BUSY = 5;
  localparam int UO_RX_BUSY = 6;

  // Reload value for a down-counter that must expire after n cycles.
  function automatic int cnt_reload(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/tt_um_uart_echo_rx.sv
// 8N1 UART receiver: two-flop synchroniser on the serial line, start-bit
// qualification at half a bit, eight LSB-first data samples and a stop-bit
// check. Emits a one-cycle valid pulse for a good byte or a one-cycle
// frame_err pulse for a bad stop bit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RX_IDLE  | line idle, waiting for a 1->0 edge on the synchronised line
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | sample one data bit every CLKS_PER_BIT cycles, LSB first
// RX_STOP  | one bit later, check the stop bit and report the result
module uart_rx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(cnt_reload(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(cnt_reload(CLKS_PER_BIT / 2));

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_CNT_W-1:0] bit_idx;
  logic [7:0]           shreg;

  // Synchronise the asynchronous line; idle level is high so reset to 1.
  // rx_prev holds the previous synchronised value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive state machine with a down-counting bit timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          // Requiring a 1->0 edge means a line stuck low after a framing
          // error is ignored until it has returned high.
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (rx_sync) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= BIT_LAST;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_sync, shreg[7:1]};
            cnt   <= BIT_LAST;
            if (bit_idx == BIT_CNT_W'(7)) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            state <= RX_IDLE;
            if (rx_sync) begin
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // The shift register only moves in RX_DATA, so it is stable while valid.
  assign data = shreg;
  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/tt_um_uart_echo.sv
// UART echo user project: bytes received on ui_in[3] are queued in a small
// FIFO and retransmitted on uo_out[4]. The last good byte is shown on
// uio_out; sticky error flags and live status are shown on uo_out.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// TX_IDLE  | line high; pop the FIFO head when one is waiting
// TX_START | drive the start bit (0) for one bit time
// TX_DATA  | drive 8 data bits LSB first, one bit time each
// TX_STOP  | drive the stop bit (1) for one bit time, then idle
module tt_um_uart_echo
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // FIFO_DEPTH must be a power of two of at least 2 so the pointer wrap
  // and the extra full/empty bit work out.
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(cnt_reload(CLKS_PER_BIT));

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_busy;

  logic       clr_meta;
  logic       clr_sync;
  logic       frame_err;
  logic       overflow;
  logic [7:0] last_byte;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       pop;
  logic       drop;
  logic [7:0] pop_data;

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_CNT_W-1:0] tx_bit;
  logic [7:0]           tx_shreg;
  logic                 txd;
  logic                 tx_busy;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, ui_in[7:4], ui_in[2:1], uio_in};

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (ui_in[3]),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr),
    .busy     (rx_busy)
  );

  // Synchronise the flag-clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_meta <= 1'b0;
      clr_sync <= 1'b0;
    end else begin
      clr_meta <= ui_in[0];
      clr_sync <= clr_meta;
    end
  end

  // FIFO status from the extra pointer bit. A pop in the same cycle frees
  // the slot the push needs, so a full FIFO still accepts that byte.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = (tx_state == TX_IDLE) && !fifo_empty;
    push       = rx_valid && (!fifo_full || pop);
    drop       = rx_valid && fifo_full && !pop;
    pop_data   = mem[rd_ptr[AW-1:0]];
  end

  // FIFO storage and pointers; contents are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= rx_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky error flags and last-byte display; a new error beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      last_byte <= '0;
    end else begin
      if (rx_ferr) begin
        frame_err <= 1'b1;
      end else if (clr_sync) begin
        frame_err <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_sync) begin
        overflow <= 1'b0;
      end
      if (rx_valid) begin
        last_byte <= rx_data;
      end
    end
  end

  // Transmit state machine. txd is registered from the current state, so
  // it trails the state by one cycle uniformly and every bit lasts exactly
  // CLKS_PER_BIT cycles; the pop cycle in TX_IDLE gives the single idle
  // cycle between back-to-back frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_START: txd <= 1'b0;
        TX_DATA:  txd <= tx_shreg[0];
        default:  txd <= 1'b1;
      endcase
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_shreg <= pop_data;
            tx_cnt   <= BIT_LAST;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_LAST;
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            if (tx_bit == BIT_CNT_W'(7)) begin
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // Status byte assembly.
  always_comb begin
    uo_out             = '0;
    uo_out[UO_EMPTY]   = fifo_empty;
    uo_out[UO_FULL]    = fifo_full;
    uo_out[UO_FERR]    = frame_err;
    uo_out[UO_OVF]     = overflow;
    uo_out[UO_TXD]     = txd;
    uo_out[UO_TX_BUSY] = tx_busy;
    uo_out[UO_RX_BUSY] = rx_busy;
  end

  assign uio_out = last_byte;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uart_echo.sv
// Bench for tt_um_uart_echo: directed UART frames in, scoreboard queue of
// expected echoes, and an independent txd frame decoder that pops and
// compares whenever a frame appears on the output.
module tb_tt_um_uart_echo;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic txd, tx_busy, rx_busy, f_empty, f_full, f_err, f_ovf;
  assign f_empty = uo_out[0];
  assign f_full  = uo_out[1];
  assign f_err   = uo_out[2];
  assign f_ovf   = uo_out[3];
  assign txd     = uo_out[4];
  assign tx_busy = uo_out[5];
  assign rx_busy = uo_out[6];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic mon_en;
  int frames_seen = 0;
  int full_cycles = 0;

  tt_um_uart_echo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one frame starting at the current (negedge) time.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
    ui_in[3] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ui_in[3] = b[i];
      repeat (CPB) @(negedge clk);
    end
    ui_in[3] = stop_val;
    repeat (stop_len) @(negedge clk);
    ui_in[3] = 1'b1;
  endtask

  // Checks stop-sample to start-edge latency and the exact txd waveform.
  task automatic check_echo_timing(input logic [7:0] b);
    int n;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    n = 0;
    while (!rx_busy && n < 200) begin @(negedge clk); n++; end
    chk("rx_busy_rise", int'(n < 200), 1);
    n = 0;
    while (rx_busy && n < 200) begin @(negedge clk); n++; end
    chk("rx_busy_fall", int'(n < 200), 1);
    n = 0;
    while (txd && n < 20) begin @(negedge clk); n++; end
    chk("echo_latency", n, 3);
    for (int k = 0; k < 80; k++) begin
      chk("txd_frame", int'(txd), int'(frame[k/CPB]));
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(f_empty && !tx_busy) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_timeout", int'(n < 3000), 1);
    repeat (10) @(negedge clk);
  endtask

  // Counts cycles with the FIFO full.
  always @(negedge clk) begin
    if (f_full) full_cycles <= full_cycles + 1;
  end

  // Output monitor: decode every txd frame at mid-bit and score it.
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    logic       stop_b;
    forever begin
      @(negedge clk);
      if (rst_n && txd == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        stop_b = txd;
        frames_seen++;
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_echo", int'(d), -1);
          end else begin
            e = exp_q.pop_front();
            chk("echo_byte", int'(d), int'(e));
            chk("echo_stop", int'(stop_b), 1);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int f0;
    int fc0;
    int lows;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h08;
    uio_in = 8'h00;
    mon_en = 1'b1;

    // Reset applied mid-cycle takes effect immediately.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_uo_out", int'(uo_out), 8'h11);
    chk("reset_uio_out", int'(uio_out), 8'h00);
    chk("reset_uio_oe", int'(uio_oe), 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single echo with exact waveform and latency.
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1, CPB);
      check_echo_timing(8'hA5);
    join
    chk("single_uio_out", int'(uio_out), 8'hA5);
    wait_drain();

    // Back-to-back full-length frames: TX keeps pace, nothing dropped.
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, CPB);
    end
    wait_drain();
    chk("burst_no_overflow", int'(f_ovf), 0);
    chk("burst_sb_empty", exp_q.size(), 0);
    chk("burst_uio_out", int'(uio_out), 8'h06);

    // Shortened stop bits make RX outrun TX until the FIFO overflows.
    mon_en = 1'b0;
    f0  = frames_seen;
    fc0 = full_cycles;
    for (int i = 0; i < 160; i++) begin
      send_byte(8'(i), 1'b1, 6);
    end
    repeat (20) @(negedge clk);
    chk("ovf_flag", int'(f_ovf), 1);
    chk("ovf_full_seen", int'(full_cycles > fc0), 1);
    chk("ovf_uio_out", int'(uio_out), 8'h9F);
    wait_drain();
    chk("ovf_some_dropped", int'((frames_seen - f0) < 160), 1);
    chk("ovf_most_echoed", int'((frames_seen - f0) >= 140), 1);
    chk("ovf_empty_after", int'(f_empty), 1);
    mon_en = 1'b1;

    // Frame error: bad stop bit, nothing echoed, display unchanged.
    send_byte(8'h3C, 1'b0, CPB);
    repeat (30) @(negedge clk);
    chk("ferr_flag", int'(f_err), 1);
    chk("ferr_uio_out", int'(uio_out), 8'h9F);
    chk("ferr_no_push", int'(f_empty), 1);
    chk("ferr_tx_idle", int'(tx_busy), 0);
    ui_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr_ferr", int'(f_err), 0);
    chk("clr_ovf", int'(f_ovf), 0);

    // Short glitch on the line is rejected at the start-bit check.
    ui_in[3] = 1'b0;
    repeat (2) @(negedge clk);
    ui_in[3] = 1'b1;
    n = 0;
    while (!rx_busy && n < 10) begin @(negedge clk); n++; end
    chk("glitch_busy_rise", int'(n < 10), 1);
    n = 0;
    while (rx_busy && n < 20) begin @(negedge clk); n++; end
    chk("glitch_busy_fall", int'(n < 20), 1);
    repeat (100) @(negedge clk);
    chk("glitch_no_push", int'(f_empty), 1);
    chk("glitch_tx_idle", int'(tx_busy), 0);
    chk("glitch_uio_out", int'(uio_out), 8'h9F);
    chk("sb_drained", exp_q.size(), 0);

    // Reset during TX data bit 3 forces txd high at once.
    mon_en = 1'b0;
    fork
      send_byte(8'h55, 1'b1, CPB);
      begin
        n = 0;
        while (txd && n < 300) begin @(negedge clk); n++; end
        chk("rst_tx_start", int'(n < 300), 1);
      end
    join
    repeat (CPB + 3 * CPB + CPB / 2 - 1) @(negedge clk);
    chk("rst_pre_txd", int'(txd), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_txd_high", int'(txd), 1);
    chk("rst_fifo_empty", int'(f_empty), 1);
    chk("rst_tx_busy", int'(tx_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    chk("rst_no_output", lows, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
